decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered RV32I decode stage that supersedes the combinational decoder. Decodes one
//  instruction per cycle into instruction_t and sits between fetch and the register-read/execute
//  stage. Adds a valid/ready handshake, an optional skid buffer, flush, and strict illegal-encoding
//  checks. Optionally decodes RV32M and SYSTEM/FENCE, and keeps a saturating illegal-instruction
//  counter.
// PARAMETERS
//  ENABLE_M       0   1: decode OP funct7=0000001 as MUL/DIV; 0: such encodings are illegal
//  ENABLE_SYSTEM  0   1: decode ECALL/EBREAK/FENCE; 0: opcodes 1110011/0001111 are illegal
//  STRICT         1   1: full funct3/funct7 legality checks; 0: opcode-only check
//  SKID_BUFFER    1   1: 2-entry skid, o_ready registered; 0: 1 entry, o_ready combinational
//  CNT_W          16  width of o_illegal_count
// PORTS
//  i_clk            in   1      clock
//  i_rst            in   1      synchronous active-high reset
//  i_instr          in   32     raw instruction word
//  i_pc             in   32     PC of i_instr
//  i_valid          in   1      upstream instruction valid
//  o_ready          out  1      stage can accept (transfer = i_valid & o_ready)
//  i_flush          in   1      discard all held and incoming instructions
//  o_valid          out  1      o_out* valid
//  i_ready          in   1      downstream accepts (transfer = o_valid & i_ready)
//  o_out            out  struct instruction_t decoded fields (same encoding rules as RV32I decode)
//  o_is_muldiv      out  1      RV32M op; o_out.alu_op = {1'b0, funct3}
//  o_sys_op         out  2      00 none, 01 ECALL, 10 EBREAK, 11 FENCE (treated as NOP)
//  o_illegal_count  out  CNT_W  illegal instructions delivered downstream, saturating
// BEHAVIOUR
//  - Reset: o_valid=0, o_out all zero, o_is_muldiv=0, o_sys_op=0, o_illegal_count=0.
//    With SKID_BUFFER=1, o_ready=1 in the first cycle after reset.
//  - Latency: an instruction accepted in cycle N appears on o_out in cycle N+1 when the output
//    register is empty. Throughput is 1 per cycle while i_ready=1.
//  - SKID_BUFFER=0: o_ready = !o_valid | i_ready. One output register.
//  - SKID_BUFFER=1: o_ready is registered and equals !skid_full. A beat accepted while the output
//    register is held goes into the skid register. The skid drains into the output register on
//    the next downstream transfer.
//  - Ordering is strictly FIFO. No beat is dropped or duplicated under any pattern of
//    i_valid/i_ready.
//  - i_flush (priority over everything but reset): the next cycle has o_valid=0 and both
//    entries empty. A beat offered in the flush cycle is discarded. Its counter increment is
//    suppressed.
//  - Decode fields: rs1_pc, rs2_imm, branch, jump, loadstore, load_zeroextend, rd/rs1/rs2_addr,
//    alu_op and imm follow the RV32I rules.
//  - Immediate formats: I/S/B/J/U, sign-extended to 32 bits. LUI has rs1_addr=0. STORE and
//    BRANCH have rd_addr=0.
//  - Illegal when STRICT=1, in addition to unknown opcodes:
//    OP funct7 not 0000000, 0100000 (ADD/SUB and SRL/SRA only), or 0000001 (M only);
//    SLLI/SRLI/SRAI funct7 mismatch; LOAD funct3 in {3,6,7}; STORE funct3 >= 3;
//    BRANCH funct3 in {2,3}; JALR funct3 != 0; SYSTEM not exactly ECALL (0x00000073) or
//    EBREAK (0x00100073).
//  - Illegal beats are still delivered, with inst_invalid=1 and side effects killed:
//    rd_addr=0, loadstore=0, branch=0, jump=0, o_is_muldiv=0, o_sys_op=0.
//  - o_illegal_count increments by 1 on each downstream transfer with inst_invalid=1. It holds
//    at 2^CNT_W-1 once reached.
//  - While o_valid=1 and i_ready=0, every output is stable.
//  - Reset in mid-stream drops all entries, same as the reset values.
// TESTING
//  - 0x00500093 (addi x1,x0,5), pc=0x100, i_ready=1 -> next cycle o_valid=1, imm=5, rd=1,
//    rs2_imm=1, alu_op=0, pc=0x100.
//  - 0x022081B3 (mul x3,x1,x2): ENABLE_M=1 -> o_is_muldiv=1, alu_op=0, rd=3.
//    ENABLE_M=0 -> inst_invalid=1, rd=0, o_illegal_count=1.
//  - 4 back-to-back beats with i_ready low for cycles 2-4 (SKID_BUFFER=1) -> o_ready falls
//    once 2 entries are held. All 4 beats emerge in order, none duplicated.
//  - i_flush asserted with both entries full and i_valid=1 -> next cycle o_valid=0, o_ready=1.
//    The flushed beats never appear.
//  - 0x00003003 (ld, funct3=3) x5 with CNT_W=2 -> inst_invalid=1, loadstore=0, count 1,2,3,3.
//  - i_rst pulsed one cycle with o_valid=1 -> next cycle o_valid=0, count=0, o_out zero.

Source files
------------

// File: rtl/decode_stage.sv
// Registered RV32I(+M/SYSTEM) decode stage with a valid/ready handshake, optional
// two-entry skid buffer, flush, strict legality checks and a saturating illegal counter.
package decode_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_pc;
    logic        rs2_imm;
    logic        branch;
    logic        jump;
    logic        loadstore;
    logic        load_zeroextend;
    logic        inst_invalid;
  } instruction_t;

  typedef struct packed {
    instruction_t ins;
    logic         muldiv;
    logic [1:0]   sys_op;
  } beat_t;
endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int ENABLE_M      = 0,
  parameter int ENABLE_SYSTEM = 0,
  parameter int STRICT        = 1,
  parameter int SKID_BUFFER   = 1,
  parameter int CNT_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_instr,
  input  logic [31:0]      i_pc,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output instruction_t     o_out,
  output logic             o_is_muldiv,
  output logic [1:0]       o_sys_op,
  output logic [CNT_W-1:0] o_illegal_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  beat_t            dec_p0;
  beat_t            out_q, out_d, skid_q, skid_d;
  logic             out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_xfer, out_xfer, ill;
  logic [6:0]       opc, f7;
  logic [2:0]       f3;
  logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = i_instr[6:0];
  assign f3    = i_instr[14:12];
  assign f7    = i_instr[31:25];
  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign imm_u = {i_instr[31:12], 12'b0};
  assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  // Stage 0: combinational decode of the incoming word
  always_comb begin
    dec_p0              = '0;
    ill                 = 1'b0;
    dec_p0.ins.pc       = i_pc;
    dec_p0.ins.rd_addr  = i_instr[11:7];
    dec_p0.ins.rs1_addr = i_instr[19:15];
    dec_p0.ins.rs2_addr = i_instr[24:20];
    case (opc)
      7'b0110111: begin
        dec_p0.ins.rs1_addr = 5'd0;
        dec_p0.ins.rs2_imm  = 1'b1;
        dec_p0.ins.imm      = imm_u;
      end
      7'b0010111: begin
        dec_p0.ins.rs1_pc  = 1'b1;
        dec_p0.ins.rs2_imm = 1'b1;
        dec_p0.ins.imm     = imm_u;
      end
      7'b1101111: begin
        dec_p0.ins.jump    = 1'b1;
        dec_p0.ins.rs1_pc  = 1'b1;
        dec_p0.ins.rs2_imm = 1'b1;
        dec_p0.ins.imm     = imm_j;
      end
      7'b1100111: begin
        dec_p0.ins.jump    = 1'b1;
        dec_p0.ins.rs2_imm = 1'b1;
        dec_p0.ins.imm     = imm_i;
        ill = (STRICT != 0) && (f3 != 3'd0);
      end
      7'b1100011: begin
        dec_p0.ins.branch  = 1'b1;
        dec_p0.ins.rd_addr = 5'd0;
        dec_p0.ins.imm     = imm_b;
        dec_p0.ins.alu_op  = {1'b0, f3};
        ill = (STRICT != 0) && (f3[2:1] == 2'b01);
      end
      7'b0000011: begin
        dec_p0.ins.loadstore       = 1'b1;
        dec_p0.ins.rs2_imm         = 1'b1;
        dec_p0.ins.imm             = imm_i;
        dec_p0.ins.load_zeroextend = f3[2];
        ill = (STRICT != 0) && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      7'b0100011: begin
        dec_p0.ins.loadstore = 1'b1;
        dec_p0.ins.rs2_imm   = 1'b1;
        dec_p0.ins.rd_addr   = 5'd0;
        dec_p0.ins.imm       = imm_s;
        ill = (STRICT != 0) && (f3 >= 3'd3);
      end
      7'b0010011: begin
        dec_p0.ins.rs2_imm = 1'b1;
        dec_p0.ins.imm     = imm_i;
        // bit 30 selects SRAI only for the right-shift group; elsewhere it is immediate data
        dec_p0.ins.alu_op  = (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
        ill = (STRICT != 0) &&
              (((f3 == 3'd1) && (f7 != 7'd0)) ||
               ((f3 == 3'd5) && (f7 != 7'd0) && (f7 != 7'b0100000)));
      end
      7'b0110011: begin
        if (f7 == 7'b0000001) begin
          dec_p0.muldiv     = (ENABLE_M != 0);
          dec_p0.ins.alu_op = {1'b0, f3};
          ill = (ENABLE_M == 0);
        end else begin
          dec_p0.ins.alu_op = {f7[5], f3};
          ill = (STRICT != 0) &&
                !((f7 == 7'd0) || ((f7 == 7'b0100000) && (f3 == 3'd0 || f3 == 3'd5)));
        end
      end
      7'b0001111: begin
        dec_p0.ins.rd_addr = 5'd0;
        dec_p0.ins.imm     = imm_i;
        dec_p0.sys_op      = 2'b11;
        ill = (ENABLE_SYSTEM == 0);
      end
      7'b1110011: begin
        dec_p0.ins.rd_addr = 5'd0;
        dec_p0.ins.imm     = imm_i;
        if (STRICT == 0)                  dec_p0.sys_op = i_instr[20] ? 2'b10 : 2'b01;
        else if (i_instr == 32'h00000073) dec_p0.sys_op = 2'b01;
        else if (i_instr == 32'h00100073) dec_p0.sys_op = 2'b10;
        else                              ill = 1'b1;
        if (ENABLE_SYSTEM == 0) ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec_p0.ins.inst_invalid = 1'b1;
      dec_p0.ins.rd_addr      = 5'd0;
      dec_p0.ins.loadstore    = 1'b0;
      dec_p0.ins.branch       = 1'b0;
      dec_p0.ins.jump         = 1'b0;
      dec_p0.muldiv           = 1'b0;
      dec_p0.sys_op           = 2'b00;
    end
  end

  assign o_ready  = (SKID_BUFFER != 0) ? rdy_q : (!out_vld_q || i_ready);
  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = out_vld_q && i_ready;

  // Stage 1: output register plus skid entry
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    rdy_d      = rdy_q;
    cnt_d      = cnt_q;
    if (i_flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
      rdy_d      = 1'b1;
    end else begin
      if (out_xfer && out_q.ins.inst_invalid) cnt_d = sat_inc(cnt_q);
      if (SKID_BUFFER != 0) begin
        if (!out_vld_q || i_ready) begin
          if (skid_vld_q) begin
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = in_xfer;
            if (in_xfer) skid_d = dec_p0;
          end else begin
            out_vld_d = in_xfer;
            if (in_xfer) out_d = dec_p0;
          end
        end else if (in_xfer) begin
          skid_d     = dec_p0;
          skid_vld_d = 1'b1;
        end
        rdy_d = !skid_vld_d;
      end else begin
        if (in_xfer) begin
          out_d     = dec_p0;
          out_vld_d = 1'b1;
        end else if (out_xfer) begin
          out_vld_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
      cnt_q      <= cnt_d;
    end
    skid_q <= skid_d;
  end

  assign o_valid         = out_vld_q;
  assign o_out           = out_q.ins;
  assign o_is_muldiv     = out_q.muldiv;
  assign o_sys_op        = out_q.sys_op;
  assign o_illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus skid, flush, saturation and reset sequences.
module tb_decode_stage;
  import decode_pkg::*;

  logic         clk = 1'b0;
  logic         rst, flush, valid, ready;
  logic [31:0]  instr, pc;
  logic         o_ready, o_valid, md;
  logic [1:0]   sys;
  logic [1:0]   cnt;
  instruction_t o_out;
  logic         r0, v0, md0;
  logic [1:0]   sys0;
  logic [15:0]  cnt0;
  instruction_t out0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_stage #(.ENABLE_M(1), .ENABLE_SYSTEM(1), .STRICT(1), .SKID_BUFFER(1), .CNT_W(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_pc(pc), .i_valid(valid), .o_ready(o_ready),
    .i_flush(flush), .o_valid(o_valid), .i_ready(ready), .o_out(o_out),
    .o_is_muldiv(md), .o_sys_op(sys), .o_illegal_count(cnt));

  decode_stage #(.ENABLE_M(0), .ENABLE_SYSTEM(0), .STRICT(1), .SKID_BUFFER(0), .CNT_W(16)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_pc(pc), .i_valid(valid), .o_ready(r0),
    .i_flush(flush), .o_valid(v0), .i_ready(ready), .o_out(out0),
    .o_is_muldiv(md0), .o_sys_op(sys0), .o_illegal_count(cnt0));

  typedef struct {
    logic [31:0] instr;
    logic        inv;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [5:0]  flg;   // {rs1_pc, rs2_imm, branch, jump, loadstore, load_zeroextend}
    logic        md;
    logic [1:0]  sys;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input int rd);
    return 32'h00000013 | (32'(rd) << 7) | (32'(rd) << 20);
  endfunction

  vec_t        tbl[17];
  logic [4:0]  got[$];
  instruction_t held;
  int          idx, seen;
  bit          saw_low;

  initial begin
    tbl[0]  = '{32'h00500093, 0, 5'd1, 5'd0, 5'd5,  32'h00000005, 4'h0, 6'b010000, 0, 2'b00};
    tbl[1]  = '{32'h022081B3, 0, 5'd3, 5'd1, 5'd2,  32'h00000000, 4'h0, 6'b000000, 1, 2'b00};
    tbl[2]  = '{32'h40208133, 0, 5'd2, 5'd1, 5'd2,  32'h00000000, 4'h8, 6'b000000, 0, 2'b00};
    tbl[3]  = '{32'h0040C183, 0, 5'd3, 5'd1, 5'd4,  32'h00000004, 4'h0, 6'b010011, 0, 2'b00};
    tbl[4]  = '{32'hFE20AE23, 0, 5'd0, 5'd1, 5'd2,  32'hFFFFFFFC, 4'h0, 6'b010010, 0, 2'b00};
    tbl[5]  = '{32'h00208463, 0, 5'd0, 5'd1, 5'd2,  32'h00000008, 4'h0, 6'b001000, 0, 2'b00};
    tbl[6]  = '{32'h010000EF, 0, 5'd1, 5'd0, 5'd16, 32'h00000010, 4'h0, 6'b110100, 0, 2'b00};
    tbl[7]  = '{32'h123452B7, 0, 5'd5, 5'd0, 5'd3,  32'h12345000, 4'h0, 6'b010000, 0, 2'b00};
    tbl[8]  = '{32'h00001317, 0, 5'd6, 5'd0, 5'd0,  32'h00001000, 4'h0, 6'b110000, 0, 2'b00};
    tbl[9]  = '{32'h00008067, 0, 5'd0, 5'd1, 5'd0,  32'h00000000, 4'h0, 6'b010100, 0, 2'b00};
    tbl[10] = '{32'h4030D393, 0, 5'd7, 5'd1, 5'd3,  32'h00000403, 4'hD, 6'b010000, 0, 2'b00};
    tbl[11] = '{32'h00000073, 0, 5'd0, 5'd0, 5'd0,  32'h00000000, 4'h0, 6'b000000, 0, 2'b01};
    tbl[12] = '{32'h00100073, 0, 5'd0, 5'd0, 5'd1,  32'h00000001, 4'h0, 6'b000000, 0, 2'b10};
    tbl[13] = '{32'h0FF0000F, 0, 5'd0, 5'd0, 5'd31, 32'h000000FF, 4'h0, 6'b000000, 0, 2'b11};
    tbl[14] = '{32'h00003003, 1, 5'd0, 5'd0, 5'd0,  32'h00000000, 4'h0, 6'b010000, 0, 2'b00};
    tbl[15] = '{32'h40109093, 1, 5'd0, 5'd1, 5'd1,  32'h00000401, 4'h1, 6'b010000, 0, 2'b00};
    tbl[16] = '{32'h0000007F, 1, 5'd0, 5'd0, 5'd0,  32'h00000000, 4'h0, 6'b000000, 0, 2'b00};

    rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b1; instr = '0; pc = '0;
    step(); step();
    chk("rst_valid", o_valid, 0);
    chk("rst_out", o_out, 0);
    chk("rst_side", {md, sys, cnt}, 0);
    chk("rst_ready", o_ready, 1);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      valid = 1'b1; instr = tbl[i].instr; pc = 32'h100 + 32'(4 * i);
      step();
      chk($sformatf("dec%0d", i),
          {o_valid, o_out.pc, o_out.inst_invalid, o_out.rd_addr, o_out.rs1_addr, o_out.rs2_addr,
           o_out.imm, o_out.alu_op, o_out.rs1_pc, o_out.rs2_imm, o_out.branch, o_out.jump,
           o_out.loadstore, o_out.load_zeroextend, md, sys},
          {1'b1, 32'h100 + 32'(4 * i), tbl[i].inv, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
           tbl[i].imm, tbl[i].alu, tbl[i].flg, tbl[i].md, tbl[i].sys});
      if (i == 1) chk("m_off_mul", {v0, out0.inst_invalid, out0.rd_addr, md0}, {1'b1, 1'b1, 5'd0, 1'b0});
    end
    valid = 1'b0;
    step();
    chk("tbl_drained", o_valid, 0);
    chk("tbl_count", cnt, 3);
    chk("m_off_count", cnt0, 7);

    idx = 0; saw_low = 0;
    for (int c = 0; c < 14; c++) begin
      ready = !(c >= 2 && c <= 4);
      valid = (idx < 4);
      instr = addi(idx + 1);
      @(negedge clk);
      if (!o_ready) saw_low = 1;
      if (c == 3) held = o_out;
      if (c == 4) chk("stall_stable", o_out, held);
      if (o_valid && ready) got.push_back(o_out.rd_addr);
      if (valid && o_ready) idx++;
      step();
    end
    chk("skid_ready_fell", saw_low, 1);
    chk("skid_accepted", idx, 4);
    chk("skid_count", got.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("skid_order%0d", k), (k < got.size()) ? got[k] : 5'h1F, k + 1);

    ready = 1'b0; valid = 1'b1; instr = addi(5);
    step();
    instr = addi(6);
    step();
    instr = addi(7); flush = 1'b1;
    chk("full_ready_low", {o_valid, o_ready}, 2'b10);
    step();
    flush = 1'b0; valid = 1'b0;
    chk("flush_valid", o_valid, 0);
    chk("flush_ready", o_ready, 1);
    ready = 1'b1; seen = 0;
    repeat (3) begin
      step();
      if (o_valid) seen++;
    end
    chk("flush_no_leak", seen, 0);
    valid = 1'b1; instr = addi(8);
    step();
    valid = 1'b0;
    chk("post_flush_beat", {o_valid, o_out.rd_addr}, {1'b1, 5'd8});

    rst = 1'b1;
    step();
    rst = 1'b0; ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      valid = (k < 5); instr = 32'h00003003;
      step();
      if (k < 5) chk($sformatf("ld_flags%0d", k), {o_valid, o_out.inst_invalid, o_out.loadstore}, 3'b110);
      if (k >= 1) chk($sformatf("ld_count%0d", k), cnt, (k < 3) ? k : 3);
    end

    ready = 1'b0; valid = 1'b1; instr = addi(9);
    step();
    valid = 1'b0;
    chk("pre_rst_valid", {o_valid, cnt}, {1'b1, 2'd3});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_count", cnt, 0);
    chk("mid_rst_out", {o_out, md, sys}, 0);
    chk("mid_rst_ready", o_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
